// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the FIFO stream reader slice.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned BUF_DEPTH_DEF  = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) res++;
        return res;
    endfunction

    // Index width that stays legal (>= 1 bit) even for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned range);
        return (clog2(range) == 0) ? 1 : clog2(range);
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Backpressured valid/ready stream with burst framing (last flag).
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_skid.sv
// Circular prefetch buffer: push at tail, pop at head, occupancy count.
module fifo_stream_skid
    import fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
    localparam int unsigned PW         = idx_width(BUF_DEPTH),
    localparam int unsigned CW         = cnt_width(BUF_DEPTH)
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CW-1:0]         count,
    output logic                  full
);

    logic [PW-1:0]         head_q, tail_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic                  push_ok, pop_ok;

    assign full    = (count_q == CW'(BUF_DEPTH));
    // A same-cycle pop makes room, so a push into a full buffer is still legal then.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && (count_q != '0);

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) tail_q <= tail_q + 1'b1;
            if (pop_ok)  head_q <= head_q + 1'b1;
            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (push_ok) mem_q[tail_q] <= push_data;
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO pop interface to valid/ready burst stream converter (read clock domain).
// Optional statistics counters enabled by defining FIFO_STREAM_READER_STATS_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned BUF_DEPTH  = BUF_DEPTH_DEF,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   rd_clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic                   fifo_valid,
    input  logic [DATA_WIDTH-1:0]  fifo_dout,
    fifo_stream_reader_if.master   m_if,
    output logic                   idle,
    output logic                   err_ovf
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]   stat_beats,
    output logic [CNT_WIDTH-1:0]   stat_stalls
`endif
);

    localparam int unsigned CW = cnt_width(BUF_DEPTH);
    localparam int unsigned BW = idx_width(BURST_LEN);
    localparam logic [BW-1:0] LastBeat = BW'(BURST_LEN - 1);

    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || BURST_LEN < 1 ||
        CNT_WIDTH < 1) begin : g_bad_params
        $error("fifo_stream_reader: illegal parameter combination");
    end

    logic          inflight_q, rst_q, err_ovf_q;
    logic [BW-1:0] beat_q, beat_d;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          full, pop, push;

    assign pop  = m_if.m_valid && m_if.m_ready;
    // Data landing in the cycle right after reset belongs to a pre-reset request.
    assign push = fifo_valid && !rst_q;

    assign occupancy  = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign fifo_rd_en = enable && !rst && !fifo_empty && (occupancy < (CW+1)'(BUF_DEPTH));

    fifo_stream_skid #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_skid (
        .rd_clk    (rd_clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_dout),
        .pop       (pop),
        .head_data (m_if.m_data),
        .count     (count),
        .full      (full)
    );

    assign m_if.m_valid = (count != '0);
    assign m_if.m_last  = m_if.m_valid && (beat_q == LastBeat);
    assign idle         = (count == '0) && !inflight_q;
    assign err_ovf      = err_ovf_q;

    always_comb begin
        beat_d = beat_q;
        if (pop) beat_d = (beat_q == LastBeat) ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge rd_clk) begin
        rst_q <= rst;
        if (rst) begin
            inflight_q <= 1'b0;
            beat_q     <= '0;
            err_ovf_q  <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en && !fifo_empty;
            beat_q     <= beat_d;
            if (push && full && !pop) err_ovf_q <= 1'b1;
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNT_WIDTH-1:0] beats_q, stalls_q;

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (pop && !(&beats_q)) beats_q <= beats_q + 1'b1;
            if (m_if.m_valid && !m_if.m_ready && !(&stalls_q)) stalls_q <= stalls_q + 1'b1;
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised bench: FIFO source model plus in-order scoreboard for the stream reader.
module tb_fifo_stream_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned BD = 2;
    localparam int unsigned BL = 8;
    localparam int unsigned CW = 4;

    logic          rd_clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic          fifo_valid = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          idle, err_ovf;
`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CW-1:0] stat_beats, stat_stalls;
    int            beats_m, stalls_m;
`endif

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BD),
        .BURST_LEN  (BL),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk      (rd_clk),
        .rst         (rst),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_valid  (fifo_valid),
        .fifo_dout   (fifo_dout),
        .m_if        (s_if),
        .idle        (idle),
        .err_ovf     (err_ovf)
`ifdef FIFO_STREAM_READER_STATS_EN
        ,
        .stat_beats  (stat_beats),
        .stat_stalls (stat_stalls)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] src_q [$];   // words still held by the upstream FIFO
    logic [DW-1:0] exp_q [$];   // words popped from the FIFO but not yet delivered
    int            delivered, beat_idx, cyc, ready_mode;
    bit            infl_m, hold_pend, last_rd_en, last_valid, last_pop;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) src_q.push_back(base + DW'(i));
        fifo_empty = (src_q.size() == 0);
    endtask

    // One clock: sample and score at negedge, then advance the FIFO model after the edge.
    task automatic step();
        logic          pop_now, issue_now;
        logic [DW-1:0] w;
        @(negedge rd_clk);
        pop_now    = s_if.m_valid && s_if.m_ready && !rst;
        issue_now  = fifo_rd_en && !fifo_empty;
        last_rd_en = fifo_rd_en;
        last_valid = s_if.m_valid;
        last_pop   = pop_now;
        if (rst || fifo_empty) check("rd_en_blocked", fifo_rd_en, 1'b0);
        check("m_valid", s_if.m_valid, exp_q.size() > int'(infl_m));
        check("idle", idle, exp_q.size() == 0);
        check("occupancy", exp_q.size() <= BD, 1'b1);
        if (hold_pend) begin
            check("hold_valid", s_if.m_valid, 1'b1);
            check("hold_data", s_if.m_data, hold_data);
            check("hold_last", s_if.m_last, hold_last);
        end
        hold_pend = s_if.m_valid && !s_if.m_ready && !rst;
        hold_data = s_if.m_data;
        hold_last = s_if.m_last;
        if (pop_now) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("m_data", s_if.m_data, exp_q.pop_front());
                check("m_last", s_if.m_last, (beat_idx % BL) == BL - 1);
            end
            beat_idx++;
            delivered++;
        end
`ifdef FIFO_STREAM_READER_STATS_EN
        check("stat_beats", stat_beats, beats_m);
        check("stat_stalls", stat_stalls, stalls_m);
        if (!rst) begin
            if (pop_now && beats_m < (1 << CW) - 1) beats_m++;
            if (s_if.m_valid && !s_if.m_ready && stalls_m < (1 << CW) - 1) stalls_m++;
        end
`endif
        @(posedge rd_clk);
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            beat_idx   = 0;
            infl_m     = 1'b0;
            fifo_valid = 1'b0;
            hold_pend  = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
            beats_m  = 0;
            stalls_m = 0;
`endif
        end else begin
            infl_m = issue_now;
            if (issue_now) begin
                w = src_q.pop_front();
                exp_q.push_back(w);
                fifo_valid = 1'b1;
                fifo_dout  = w;
            end else begin
                fifo_valid = 1'b0;
            end
        end
        fifo_empty = (src_q.size() == 0);
        case (ready_mode)
            0:       s_if.m_ready = 1'b1;
            1:       s_if.m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       s_if.m_ready = 1'($urandom_range(0, 1));
            default: s_if.m_ready = 1'b0;
        endcase
    endtask

    initial begin
        int t_rd, t_v, first_p, last_p, base;
        ready_mode   = 0;
        s_if.m_ready = 1'b1;
        delivered    = 0;
        beat_idx     = 0;
        cyc          = 0;
`ifdef FIFO_STREAM_READER_STATS_EN
        beats_m  = 0;
        stalls_m = 0;
`endif

        // Reset held with a non-empty FIFO and enable high.
        load(16, 16'h0001);
        enable = 1'b1;
        @(posedge rd_clk);
        #1;
        repeat (3) step();
        check("rst_m_valid", s_if.m_valid, 1'b0);
        check("rst_m_last", s_if.m_last, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_err_ovf", err_ovf, 1'b0);
        rst = 1'b0;

        // Streaming at full rate.
        delivered = 0;
        t_rd = -1; t_v = -1; first_p = -1; last_p = -1;
        for (int i = 0; i < 100 && delivered < 16; i++) begin
            step();
            if (last_rd_en && t_rd < 0) t_rd = i;
            if (last_valid && t_v < 0)  t_v = i;
            if (last_pop && first_p < 0) first_p = i;
            if (last_pop) last_p = i;
        end
        check("stream_count", delivered, 16);
        check("first_valid_latency", t_v - t_rd, 2);
        check("stream_back_to_back", last_p - first_p, 15);
        repeat (2) step();
        check("stream_idle", idle, 1'b1);

        // Backpressure pattern 1,0,0,1.
        load(16, 16'h0100);
        ready_mode = 1;
        delivered  = 0;
        for (int i = 0; i < 200 && delivered < 16; i++) step();
        check("bp_count", delivered, 16);
        check("bp_err_ovf", err_ovf, 1'b0);

        // Enable drop mid-burst, then resume.
        load(16, 16'h0200);
        ready_mode = 0;
        delivered  = 0;
        for (int i = 0; i < 50 && delivered < 5; i++) step();
        enable = 1'b0;
        base   = delivered;
        repeat (6) step();
        check("drop_extra_beats", (delivered - base) <= 2, 1'b1);
        check("drop_valid", s_if.m_valid, 1'b0);
        check("drop_fifo_rd_en", fifo_rd_en, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 100 && delivered < 16; i++) step();
        check("drop_count", delivered, 16);

        // Random data, random ready, random enable toggling.
        for (int i = 0; i < 40; i++) src_q.push_back(DW'($urandom_range(0, 65535)));
        fifo_empty = 1'b0;
        ready_mode = 2;
        delivered  = 0;
        for (int i = 0; i < 800 && delivered < 40; i++) begin
            enable = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
            step();
        end
        check("rand_count", delivered, 40);
        enable = 1'b1;

        // Overflow: inject unrequested data into a full buffer.
        ready_mode = 3;
        load(2, 16'h0A0A);
        repeat (8) step();
        check("ovf_full_valid", s_if.m_valid, 1'b1);
        check("ovf_err_before", err_ovf, 1'b0);
        fifo_valid = 1'b1;
        fifo_dout  = 16'hDEAD;
        step();
        check("ovf_err_set", err_ovf, 1'b1);
        ready_mode = 0;
        delivered  = 0;
        repeat (6) step();
        check("ovf_drained", delivered, 2);
        check("ovf_err_sticky", err_ovf, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("ovf_err_cleared", err_ovf, 1'b0);

        // Reset mid-stream; a stale fifo_valid right after reset must be ignored.
        ready_mode = 2;
        load(12, 16'h0300);
        repeat (6) step();
        rst = 1'b1;
        step();
        rst        = 1'b0;
        fifo_valid = 1'b1;
        fifo_dout  = 16'hBEEF;
        step();
        check("rst_ignore_valid", s_if.m_valid, 1'b0);
        for (int i = 0; i < 200 && (src_q.size() != 0 || exp_q.size() != 0); i++) step();
        repeat (2) step();
        check("rst_drain_empty", exp_q.size(), 0);
        check("rst_drain_idle", idle, 1'b1);

`ifdef FIFO_STREAM_READER_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        load(10, 16'h0400);
        ready_mode = 1;
        delivered  = 0;
        for (int i = 0; i < 100 && delivered < 10; i++) step();
        step();
        check("stat_beats_10", stat_beats, 10);
        load(20, 16'h0500);
        ready_mode = 0;
        for (int i = 0; i < 100 && delivered < 30; i++) step();
        step();
        check("stat_beats_sat", stat_beats, (1 << CW) - 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
